// File: rtl/mcycle_datapath.sv
// Multicycle multiply/divide datapath: shift-add multiply and restoring divide,
// one iteration per Shift pulse, with signed fix-up in a final FIX cycle.
module mcycle_datapath #(
   parameter int width = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Init,
   input  logic             Shift,
   input  logic             MCycleOp,
   input  logic             Signed,
   input  logic [width-1:0] Operand1,
   input  logic [width-1:0] Operand2,
   output logic [width-1:0] Result1,
   output logic [width-1:0] Result2,
   output logic             ResultValid,
   output logic             DivByZero
);

   localparam int cnt_w = $clog2(width + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, next_state;
   logic [cnt_w-1:0]   count;
   logic               op_div, neg_res, neg_rem, zero_div;
   logic [width-1:0]   opb, orig_op1;
   logic [2*width-1:0] acc;

   logic               load, step, finish, last_step;
   logic [width-1:0]   abs1, abs2;
   logic [width:0]     mul_sum, rem_sh, trial;
   logic               fits;
   logic [2*width-1:0] mul_next, div_next, prod_fix;
   logic [width-1:0]   quot_fix, rem_fix, fix_r1, fix_r2;

   assign abs1      = (Signed && Operand1[width-1]) ? -Operand1 : Operand1;
   assign abs2      = (Signed && Operand2[width-1]) ? -Operand2 : Operand2;
   assign last_step = (count == cnt_w'(width - 1));

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge CLK) begin
      if (Reset) state <= IDLE;
      else       state <= next_state;
   end

   // NOTE: each always_comb assigns its outputs a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Init) next_state = RUN;
         RUN:     if (Init) next_state = RUN;
                  else if (Shift && last_step) next_state = FIX;
         FIX:     next_state = Init ? RUN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Init wins over everything else, which is what makes a restart an abort.
   always_comb begin
      load   = Init;
      step   = (state == RUN) && Shift && !Init;
      finish = (state == FIX) && !Init;
   end

   // Multiply: low half of acc holds the multiplier, opb the multiplicand.
   // Divide: acc is {rem, quot}; the trial uses width+1 bits so the shifted
   // remainder never loses its top bit when the divisor exceeds half range.
   always_comb begin
      mul_sum  = {1'b0, acc[2*width-1:width]} + {1'b0, opb};
      mul_next = acc[0] ? {mul_sum, acc[width-1:1]} : {1'b0, acc[2*width-1:1]};
      rem_sh   = acc[2*width-1:width-1];
      trial    = rem_sh - {1'b0, opb};
      fits     = (rem_sh >= {1'b0, opb});
      div_next = fits ? {trial[width-1:0], acc[width-2:0], 1'b1}
                      : {rem_sh[width-1:0], acc[width-2:0], 1'b0};
   end

   always_comb begin
      prod_fix = neg_res ? -acc : acc;
      quot_fix = neg_res ? -acc[width-1:0] : acc[width-1:0];
      rem_fix  = neg_rem ? -acc[2*width-1:width] : acc[2*width-1:width];
      fix_r1   = prod_fix[width-1:0];
      fix_r2   = prod_fix[2*width-1:width];
      if (op_div) begin
         fix_r1 = quot_fix;
         fix_r2 = rem_fix;
         if (zero_div) begin
            fix_r1 = '1;
            fix_r2 = orig_op1;
         end
      end
   end

   // NOTE: every datapath register is reset, not just the control state, so a
   // fresh operation never depends on leftovers from an aborted one.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         count       <= '0;
         op_div      <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         zero_div    <= 1'b0;
         opb         <= '0;
         orig_op1    <= '0;
         acc         <= '0;
         Result1     <= '0;
         Result2     <= '0;
         ResultValid <= 1'b0;
         DivByZero   <= 1'b0;
      end else begin
         ResultValid <= finish;
         if (load) begin
            op_div   <= MCycleOp;
            neg_res  <= Signed && (Operand1[width-1] ^ Operand2[width-1]);
            neg_rem  <= Signed && Operand1[width-1];
            zero_div <= MCycleOp && (Operand2 == '0);
            orig_op1 <= Operand1;
            opb      <= MCycleOp ? abs2 : abs1;
            acc      <= {{width{1'b0}}, (MCycleOp ? abs1 : abs2)};
            count    <= '0;
         end else if (step) begin
            acc   <= op_div ? div_next : mul_next;
            count <= count + cnt_w'(1);
         end
         if (finish) begin
            Result1   <= fix_r1;
            Result2   <= fix_r2;
            DivByZero <= zero_div;
         end
      end
   end

endmodule

// File: tb/tb_mcycle_datapath.sv
// Self-checking bench for mcycle_datapath: directed cases plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_mcycle_datapath;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         Reset, Init, Shift, MCycleOp, Signed;
   logic [W-1:0] Operand1, Operand2, Result1, Result2;
   logic         ResultValid, DivByZero;

   int           n_checks = 0;
   int           n_pass   = 0;
   logic [W-1:0] last_r1, last_r2;

   always #5 CLK = ~CLK;

   mcycle_datapath #(.width(W)) dut (
      .CLK(CLK), .Reset(Reset), .Init(Init), .Shift(Shift),
      .MCycleOp(MCycleOp), .Signed(Signed),
      .Operand1(Operand1), .Operand2(Operand2),
      .Result1(Result1), .Result2(Result2),
      .ResultValid(ResultValid), .DivByZero(DivByZero)
   );

   function automatic void model(input logic op, input logic sgn,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r1, output logic [W-1:0] r2,
                                 output logic dz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      if (!op) begin
         if (sgn) p = 64'(sa * sb);
         else     p = {32'b0, a} * {32'b0, b};
         r1 = p[31:0];
         r2 = p[63:32];
      end else if (b == '0) begin
         r1 = '1;
         r2 = a;
         dz = 1'b1;
      end else if (sgn) begin
         q  = sa / sb;
         r  = sa % sb;
         r1 = W'(q);
         r2 = W'(r);
      end else begin
         r1 = a / b;
         r2 = a % b;
      end
   endfunction

   // Issue one Init, then feed Shift every 'period' cycles up to 'npulses'.
   task automatic run_op(input string name, input logic op, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int period, input int npulses);
      logic [W-1:0] e1, e2, r1, r2;
      logic         edz, rdz;
      int           lat_exp, lat, nvalid, given;
      model(op, sgn, a, b, e1, e2, edz);
      lat_exp = (W - 1) * period + 2;
      @(negedge CLK);
      Init = 1'b1; MCycleOp = op; Signed = sgn; Operand1 = a; Operand2 = b;
      Shift = (period == 1);
      lat = -1; nvalid = 0; given = 0; r1 = '0; r2 = '0; rdz = 1'b0;
      for (int c = 0; c <= lat_exp + 4; c++) begin
         @(negedge CLK);
         Init = 1'b0;
         Operand1 = $urandom; Operand2 = $urandom;
         MCycleOp = 1'($urandom); Signed = 1'($urandom);
         if (ResultValid === 1'b1) begin
            nvalid++;
            if (lat < 0) begin lat = c; r1 = Result1; r2 = Result2; rdz = DivByZero; end
         end
         if ((c % period == 0) && (given < npulses)) begin Shift = 1'b1; given++; end
         else Shift = 1'b0;
      end
      Shift = 1'b0;
      last_r1 = e1; last_r2 = e2;
      n_checks++;
      if (lat !== lat_exp) $display("FAIL %s latency: got %0d expected %0d", name, lat, lat_exp);
      else n_pass++;
      n_checks++;
      if (nvalid !== 1) $display("FAIL %s valid_pulses: got %0d expected 1", name, nvalid);
      else n_pass++;
      n_checks++;
      if (r1 !== e1) $display("FAIL %s Result1: got %h expected %h", name, r1, e1);
      else n_pass++;
      n_checks++;
      if (r2 !== e2) $display("FAIL %s Result2: got %h expected %h", name, r2, e2);
      else n_pass++;
      n_checks++;
      if (rdz !== edz) $display("FAIL %s DivByZero: got %b expected %b", name, rdz, edz);
      else n_pass++;
      n_checks++;
      if ({Result1, Result2} !== {e1, e2})
         $display("FAIL %s hold: got %h/%h expected %h/%h", name, Result1, Result2, e1, e2);
      else n_pass++;
   endtask

   // Start an operation and give it nshift continuous iterations, counting pulses.
   task automatic start_partial(input logic op, input logic sgn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input int nshift, output int nvalid);
      nvalid = 0;
      @(negedge CLK);
      Init = 1'b1; MCycleOp = op; Signed = sgn; Operand1 = a; Operand2 = b; Shift = 1'b1;
      for (int c = 0; c < nshift; c++) begin
         @(negedge CLK);
         Init = 1'b0;
         if (ResultValid === 1'b1) nvalid++;
         Shift = 1'b1;
      end
   endtask

   task automatic test_reset();
      int nv;
      Reset = 1'b1; Init = 1'b1; Shift = 1'b1; MCycleOp = 1'b0; Signed = 1'b0;
      Operand1 = 32'd3; Operand2 = 32'd5;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({Result1, Result2} !== '0) $display("FAIL reset results: got %h/%h expected 0/0", Result1, Result2);
      else n_pass++;
      n_checks++;
      if ({ResultValid, DivByZero} !== 2'b00)
         $display("FAIL reset flags: got %b%b expected 00", ResultValid, DivByZero);
      else n_pass++;
      Reset = 1'b0; Init = 1'b0;
      nv = 0;
      repeat (W + 6) begin
         @(negedge CLK);
         if (ResultValid === 1'b1) nv++;
      end
      Shift = 1'b0;
      n_checks++;
      if (nv !== 0) $display("FAIL reset priority: got %0d valid pulses expected 0", nv);
      else n_pass++;
   endtask

   task automatic test_multiply();
      run_op("mul_3x5",      1'b0, 1'b0, 32'd3,          32'd5, 1, W);
      run_op("mul_s_m7x3",   1'b0, 1'b1, 32'hFFFF_FFF9,  32'd3, 1, W);
      run_op("mul_u_ffx2",   1'b0, 1'b0, 32'hFFFF_FFFF,  32'd2, 1, W);
      run_op("mul_s_minmin", 1'b0, 1'b1, 32'h8000_0000,  32'h8000_0000, 1, W);
   endtask

   task automatic test_divide();
      run_op("div_s_m100_7", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 1, W + 1);
      run_op("div_u_100_7",  1'b1, 1'b0, 32'd100,       32'd7, 1, W + 1);
      run_op("div_overflow", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, W + 1);
      run_op("div_u_bigdiv", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1, W + 1);
   endtask

   task automatic test_div_zero();
      run_op("div0_s_5",   1'b1, 1'b1, 32'd5,          32'd0, 1, W + 1);
      run_op("div0_u_5",   1'b1, 1'b0, 32'd5,          32'd0, 1, W + 1);
      run_op("div0_s_neg", 1'b1, 1'b1, 32'hFFFF_FF00,  32'd0, 1, W + 1);
      run_op("div_8_2",    1'b1, 1'b1, 32'd8,          32'd2, 1, W + 1);
   endtask

   task automatic test_gapped();
      run_op("gap_6x7",    1'b0, 1'b0, 32'd6,  32'd7, 3, W);
      run_op("gap_div",    1'b1, 1'b1, 32'hFFFF_FC18, 32'd13, 2, W);
   endtask

   task automatic test_shift_idle();
      int nv;
      nv = 0;
      repeat (8) begin
         @(negedge CLK);
         Shift = ~Shift;
         if (ResultValid === 1'b1) nv++;
      end
      Shift = 1'b0;
      n_checks++;
      if (nv !== 0) $display("FAIL idle_shift pulses: got %0d expected 0", nv);
      else n_pass++;
      n_checks++;
      if ({Result1, Result2} !== {last_r1, last_r2})
         $display("FAIL idle_shift hold: got %h/%h expected %h/%h", Result1, Result2, last_r1, last_r2);
      else n_pass++;
   endtask

   task automatic test_abort();
      int nv;
      start_partial(1'b0, 1'b0, 32'd1234, 32'd99, 5, nv);
      n_checks++;
      if (nv !== 0) $display("FAIL abort_run pulses: got %0d expected 0", nv);
      else n_pass++;
      run_op("abort_run_new", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd21, 1, W);
      start_partial(1'b1, 1'b0, 32'd1000, 32'd3, W, nv);
      n_checks++;
      if (nv !== 0) $display("FAIL abort_fix pulses: got %0d expected 0", nv);
      else n_pass++;
      run_op("abort_fix_new", 1'b1, 1'b0, 32'd77, 32'd5, 1, W + 1);
   endtask

   task automatic test_reset_mid();
      int nv, nv2;
      start_partial(1'b0, 1'b0, 32'd500, 32'd600, 10, nv);
      @(negedge CLK);
      Reset = 1'b1; Shift = 1'b0;
      @(negedge CLK);
      Reset = 1'b0;
      n_checks++;
      if ({Result1, Result2, ResultValid} !== '0)
         $display("FAIL reset_mid clear: got %h/%h/%b expected 0/0/0", Result1, Result2, ResultValid);
      else n_pass++;
      nv2 = 0;
      repeat (W + 4) begin
         @(negedge CLK);
         Shift = 1'b1;
         if (ResultValid === 1'b1) nv2++;
      end
      Shift = 1'b0;
      n_checks++;
      if (nv + nv2 !== 0) $display("FAIL reset_mid pulses: got %0d expected 0", nv + nv2);
      else n_pass++;
      run_op("reset_mid_9x9", 1'b0, 1'b0, 32'd9, 32'd9, 1, W);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic         op, sgn;
      int           sel;
      for (int i = 0; i < 24; i++) begin
         op  = 1'($urandom);
         sgn = 1'($urandom);
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = '0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = W'($urandom_range(1, 300));
         run_op($sformatf("rand%0d", i), op, sgn, a, b,
                $urandom_range(1, 3), W + $urandom_range(0, 1));
      end
   endtask

   initial begin
      Reset = 1'b1; Init = 1'b0; Shift = 1'b0; MCycleOp = 1'b0; Signed = 1'b0;
      Operand1 = '0; Operand2 = '0;
      last_r1 = '0; last_r2 = '0;
      test_reset();
      test_multiply();
      test_divide();
      test_div_zero();
      test_gapped();
      test_shift_idle();
      test_abort();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
